// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus the unified-memory bus for mem_access_ctrl.
// The slave modport is the controller's view; master is the requester/memory side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memData;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, memData,
    output req_ready, resp_valid, resp_rdata, resp_err, address, writeData, memRead, memWrite
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, memData,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, writeData, memRead, memWrite
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a byte-addressed memory that always writes whole words.
// Sub-word stores fetch the old word first and merge; sub-word loads are extended here.
module mem_access_ctrl #(
  parameter int RD_WAIT = 0
) (
  input logic            clk,
  input logic            reset,
  mem_access_ctrl_if.slave bus
);

  localparam int WCW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic        write_q, write_d;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  // Funct3 values the controller can execute; everything else is answered with an error.
  function automatic logic is_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    if (wr) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    end
    return ok;
  endfunction

  // Sign/zero extension of the low byte/halfword of the fetched word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b010:  r = w;
      3'b100:  r = {24'h000000, w[7:0]};
      3'b101:  r = {16'h0000, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the low byte/halfword of the old word; the memory is little-endian.
  function automatic logic [31:0] merge_word(input logic [2:0] f3, input logic [31:0] old,
                                             input logic [15:0] wd);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {old[31:8], wd[7:0]};
      3'b001:  r = {old[31:16], wd[15:0]};
      default: r = old;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    write_d      = write_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d     = bus.req_write;
          f3_d        = bus.req_funct3;
          wdata_d     = bus.req_wdata[15:0];
          req_ready_d = 1'b0;
          if (!is_legal(bus.req_write, bus.req_funct3)) begin
            // Answer immediately, memory untouched.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
            state_d      = WRITE;
            mem_write_d  = 1'b1;
            address_d    = bus.req_addr;
            write_data_d = bus.req_wdata;
          end else begin
            // Loads and sub-word stores both need the current word.
            state_d    = READ;
            mem_read_d = 1'b1;
            address_d  = bus.req_addr;
            wait_cnt_d = WCW'(RD_WAIT);
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (wait_cnt_q == {WCW{1'b0}}) begin
          mem_read_d = 1'b0;
          if (write_q) begin
            state_d      = WRITE;
            mem_write_d  = 1'b1;
            write_data_d = merge_word(f3_q, bus.memData, wdata_q);
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = fmt_load(f3_q, bus.memData);
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      WRITE: begin
        mem_write_d  = 1'b0;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
        req_ready_d  = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs, with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= {WCW{1'b0}};
      write_q      <= 1'b0;
      f3_q         <= 3'b000;
      wdata_q      <= 16'h0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      address_q    <= 32'h0000_0000;
      write_data_q <= 32'h0000_0000;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      write_q      <= write_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.address    = address_q;
  assign bus.writeData  = write_data_q;
  assign bus.memRead    = mem_read_q;
  assign bus.memWrite   = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (RD_WAIT=0 and RD_WAIT=2),
// each with its own byte-array memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus0();
  mem_access_ctrl_if bus1();

  mem_access_ctrl #(.RD_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_access_ctrl #(.RD_WAIT(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] a0, a1;

  assign a0 = bus0.address[7:0];
  assign a1 = bus1.address[7:0];
  assign bus0.memData = {mem0[8'(a0 + 8'd3)], mem0[8'(a0 + 8'd2)], mem0[8'(a0 + 8'd1)], mem0[a0]};
  assign bus1.memData = {mem1[8'(a1 + 8'd3)], mem1[8'(a1 + 8'd2)], mem1[8'(a1 + 8'd1)], mem1[a1]};

  // Word-wide memory writes on the clock edge.
  always @(posedge clk) begin
    if (bus0.memWrite) begin
      mem0[a0] <= bus0.writeData[7:0];
      mem0[8'(a0 + 8'd1)] <= bus0.writeData[15:8];
      mem0[8'(a0 + 8'd2)] <= bus0.writeData[23:16];
      mem0[8'(a0 + 8'd3)] <= bus0.writeData[31:24];
    end
    if (bus1.memWrite) begin
      mem1[a1] <= bus1.writeData[7:0];
      mem1[8'(a1 + 8'd1)] <= bus1.writeData[15:8];
      mem1[8'(a1 + 8'd2)] <= bus1.writeData[23:16];
      mem1[8'(a1 + 8'd3)] <= bus1.writeData[31:24];
    end
  end

  // Issue one request on instance 0 and observe it until resp_valid (bounded).
  // lat = number of negedges after the accept edge at which resp_valid is seen (0 = timeout).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic err, output int rdc, output int wrc,
                        output logic [31:0] wdo, output int both);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus0.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    bus0.req_valid  = 1'b1;
    bus0.req_write  = wr;
    bus0.req_funct3 = f3;
    bus0.req_addr   = addr;
    bus0.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; they must be ignored.
    bus0.req_valid  = 1'b0;
    bus0.req_addr   = 32'h0000_00F0;
    bus0.req_wdata  = 32'h5A5A_5A5A;
    bus0.req_funct3 = 3'b111;
    lat = 0; rdc = 0; wrc = 0; both = 0; rdata = 32'h0; err = 1'b0; wdo = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      if (bus0.memRead) rdc++;
      if (bus0.memWrite) begin wrc++; wdo = bus0.writeData; end
      if (bus0.memRead && bus0.memWrite) both++;
      if (bus0.resp_valid) begin
        lat = n; rdata = bus0.resp_rdata; err = bus0.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat, rdc, wrc, both;
  logic [31:0] rdata, wdo;
  logic err;

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus0.req_ready); end
    checks++; if (bus0.resp_valid !== 1'b0 || bus0.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got valid=%b err=%b expected 0/0", bus0.resp_valid, bus0.resp_err); end
    checks++; if (bus0.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus0.resp_rdata); end
    checks++; if (bus0.memRead !== 1'b0 || bus0.memWrite !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", bus0.memRead, bus0.memWrite); end
    checks++; if (bus0.address !== 32'h0 || bus0.writeData !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wd=%h expected 0/0", bus0.address, bus0.writeData); end
  endtask

  task automatic test_word;
    do_req(1'b1, 3'b010, 32'd3, 32'd200, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (wrc !== 1 || rdc !== 0) begin errors++; $display("FAIL sw_strobes: got wr=%0d rd=%0d expected 1/0", wrc, rdc); end
    checks++; if (wdo !== 32'd200) begin errors++; $display("FAIL sw_wdata: got %h expected %h", wdo, 32'd200); end
    do_req(1'b0, 3'b010, 32'd3, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (rdata !== 32'd200 || err !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b expected %h err=0", rdata, err, 32'd200); end
    checks++; if (rdc !== 1 || wrc !== 0) begin errors++; $display("FAIL lw_strobes: got rd=%0d wr=%0d expected 1/0", rdc, wrc); end
  endtask

  task automatic test_extend;
    do_req(1'b1, 3'b010, 32'd30, 32'hFFFF_FFFE, lat, rdata, err, rdc, wrc, wdo, both);
    do_req(1'b0, 3'b000, 32'd30, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL lb: got %h expected FFFFFFFE", rdata); end
    do_req(1'b0, 3'b100, 32'd30, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'h0000_00FE) begin errors++; $display("FAIL lbu: got %h expected 000000FE", rdata); end
    do_req(1'b0, 3'b001, 32'd31, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lh: got %h expected FFFFFFFF", rdata); end
    do_req(1'b0, 3'b101, 32'd32, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL lhu: got %h expected 0000FFFF", rdata); end
  endtask

  task automatic test_sb;
    do_req(1'b1, 3'b010, 32'd20, 32'h1234_5678, lat, rdata, err, rdc, wrc, wdo, both);
    do_req(1'b1, 3'b000, 32'd20, 32'h0000_00AB, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    checks++; if (rdc !== 1 || wrc !== 1 || both !== 0) begin errors++; $display("FAIL sb_strobes: got rd=%0d wr=%0d both=%0d expected 1/1/0", rdc, wrc, both); end
    checks++; if (wdo !== 32'h1234_56AB) begin errors++; $display("FAIL sb_merge: got %h expected 123456AB", wdo); end
    do_req(1'b0, 3'b010, 32'd20, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'h1234_56AB) begin errors++; $display("FAIL sb_readback: got %h expected 123456AB", rdata); end
  endtask

  task automatic test_sh;
    do_req(1'b1, 3'b010, 32'd20, 32'h1234_5678, lat, rdata, err, rdc, wrc, wdo, both);
    do_req(1'b1, 3'b001, 32'd21, 32'h0000_BEEF, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 3 || wdo !== 32'h0012_BEEF) begin errors++; $display("FAIL sh_merge: got lat=%0d wd=%h expected 3/0012BEEF", lat, wdo); end
    do_req(1'b0, 3'b010, 32'd21, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'h0012_BEEF) begin errors++; $display("FAIL sh_readback21: got %h expected 0012BEEF", rdata); end
    do_req(1'b0, 3'b010, 32'd20, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (rdata !== 32'h12BE_EF78) begin errors++; $display("FAIL sh_readback20: got %h expected 12BEEF78", rdata); end
  endtask

  task automatic test_illegal;
    logic [31:0] prev;
    prev = bus0.resp_rdata;
    do_req(1'b0, 3'b011, 32'd40, 32'd0, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL illegal_load: got lat=%0d err=%b expected 1/1", lat, err); end
    checks++; if (rdc !== 0 || wrc !== 0) begin errors++; $display("FAIL illegal_load_strobes: got rd=%0d wr=%0d expected 0/0", rdc, wrc); end
    checks++; if (rdata !== prev) begin errors++; $display("FAIL illegal_rdata_held: got %h expected %h", rdata, prev); end
    do_req(1'b1, 3'b100, 32'd40, 32'd7, lat, rdata, err, rdc, wrc, wdo, both);
    checks++; if (lat !== 1 || err !== 1'b1 || rdc !== 0 || wrc !== 0) begin errors++; $display("FAIL illegal_store: got lat=%0d err=%b rd=%0d wr=%0d expected 1/1/0/0", lat, err, rdc, wrc); end
  endtask

  task automatic test_rd_wait;
    int n_rd, l;
    logic [31:0] d;
    n_rd = 0; l = 0; d = 32'h0;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_funct3 = 3'b010;
    bus1.req_addr = 32'd40; bus1.req_wdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus1.memRead) n_rd++;
      if (bus1.resp_valid) begin l = n; d = bus1.resp_rdata; break; end
      @(negedge clk);
    end
    checks++; if (n_rd !== 3) begin errors++; $display("FAIL rdwait_read_cycles: got %0d expected 3", n_rd); end
    checks++; if (l !== 4 || d !== 32'h1122_3344) begin errors++; $display("FAIL rdwait_resp: got lat=%0d data=%h expected 4/11223344", l, d); end
  endtask

  task automatic test_reset_mid;
    int seen, l;
    seen = 0; l = 0;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'd20; bus0.req_wdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus0.memRead !== 1'b1) begin errors++; $display("FAIL rstmid_in_read: got memRead=%b expected 1", bus0.memRead); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus0.req_ready !== 1'b1 || bus0.memRead !== 1'b0 || bus0.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got ready=%b rd=%b rv=%b expected 1/0/0", bus0.req_ready, bus0.memRead, bus0.resp_valid); end
    @(negedge clk);
    if (bus0.resp_valid) seen++;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus0.resp_valid) begin l = n; rdata = bus0.resp_rdata; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d pulses expected 0", seen); end
    checks++; if (l !== 2 || rdata !== 32'h12BE_EF78) begin errors++; $display("FAIL rstmid_reaccept: got lat=%0d data=%h expected 2/12BEEF78", l, rdata); end
  endtask

  task automatic test_back_to_back;
    int l1, l2;
    logic e2;
    l1 = 0; l2 = 0; e2 = 1'b0;
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'd50; bus0.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    // Second request held while busy: an illegal load at another address.
    bus0.req_write = 1'b0; bus0.req_funct3 = 3'b011; bus0.req_addr = 32'd60;
    for (int n = 1; n <= 20; n++) begin
      if (bus0.resp_valid && l1 == 0) l1 = n;
      else if (bus0.resp_valid && l1 != 0) begin l2 = n; e2 = bus0.resp_err; bus0.req_valid = 1'b0; break; end
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    checks++; if (l1 !== 2) begin errors++; $display("FAIL b2b_first: got lat=%0d expected 2", l1); end
    checks++; if (l2 !== 4 || e2 !== 1'b1) begin errors++; $display("FAIL b2b_second: got lat=%0d err=%b expected 4/1", l2, e2); end
    checks++; if ({mem0[53], mem0[52], mem0[51], mem0[50]} !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_mem: got %h expected CAFEF00D", {mem0[53], mem0[52], mem0[51], mem0[50]}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem1[40] = 8'h44; mem1[41] = 8'h33; mem1[42] = 8'h22; mem1[43] = 8'h11;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_funct3 = 3'b000;
    bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_funct3 = 3'b000;
    bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_word;
    test_extend;
    test_sb;
    test_sh;
    test_illegal;
    test_rd_wait;
    test_reset_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
